// File: rtl/dphy_pkg.sv
// ============================================================================
// Module   : dphy_pkg
// Purpose  : Shared definitions for the D-PHY HS data-lane transmit sequencer:
//            lane state encoding, HS sync byte and LP line codes.
// Contents : lane_state_e (3-bit state codes), SYNC_BYTE, LP11/LP01/LP00
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dphy_pkg;

  // State codes are visible on Lane_State, so the encoding is fixed.
  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_HS_RQST  = 3'd1,
    ST_HS_PRPR  = 3'd2,
    ST_HS_ZERO  = 3'd3,
    ST_HS_SYNC  = 3'd4,
    ST_HS_DATA  = 3'd5,
    ST_HS_TRAIL = 3'd6,
    ST_HS_EXIT  = 3'd7
  } lane_state_e;

  // HS leader sequence byte sent just before the first payload byte.
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP line codes, {Dp, Dn}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

endpackage

`default_nettype wire

// File: rtl/dphy_state_timer.sv
// ============================================================================
// Module   : dphy_state_timer
// Purpose  : Per-state duration counter. Counts enabled cycles since the last
//            clear; a clear takes priority and loads zero.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            i_clr    - load zero on the next enabled edge
//            i_en     - count/clear enable; timer holds when low
//            o_count  - current count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dphy_state_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_clr) r_count <= '0;
      else       r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/dphy_hs_tx_seq.sv
// ============================================================================
// Module   : dphy_hs_tx_seq
// Purpose  : HS burst sequencer for one D-PHY data lane. Walks the lane through
//            LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> data -> trail ->
//            LP-11 for every HS request and owns LP levels, HS enables and
//            the HS byte stream.
// Ports    : LPTX_CLK     - lane clock
//            TxRSt        - asynchronous active-low reset
//            LPTX_EN      - synchronous enable, everything holds when low
//            TxRequestHS  - HS burst request from the protocol layer
//            TxDataHS     - payload byte
//            TxReadyHS    - payload byte accepted when high with TxRequestHS
//            TxStopState  - lane idle in Stop (LP-11)
//            LP_OE        - LP driver enable
//            LP_Dp/LP_Dn  - LP line levels
//            HSTX_EN      - HS data driver enable
//            HSCLK_EN     - HS clock request
//            HS_Byte      - byte to the HS serializer
//            Lane_State   - current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dphy_hs_tx_seq
  import dphy_pkg::*;
#(
  parameter int CNT_W          = 6,
  parameter int LPX_TIME       = 10,
  parameter int HSPREPARE_TIME = 15,
  parameter int HSZERO_TIME    = 20,
  parameter int HSTRAIL_TIME   = 8,
  parameter int HSEXIT_TIME    = 20
) (
  input  logic       LPTX_CLK,
  input  logic       TxRSt,
  input  logic       LPTX_EN,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       TxStopState,
  output logic       LP_OE,
  output logic       LP_Dp,
  output logic       LP_Dn,
  output logic       HSTX_EN,
  output logic       HSCLK_EN,
  output logic [7:0] HS_Byte,
  output logic [2:0] Lane_State
);

  // Last timer value of each timed state.
  localparam logic [CNT_W-1:0] c_LPX_LAST   = CNT_W'(LPX_TIME - 1);
  localparam logic [CNT_W-1:0] c_PRPR_LAST  = CNT_W'(HSPREPARE_TIME - 1);
  localparam logic [CNT_W-1:0] c_ZERO_LAST  = CNT_W'(HSZERO_TIME - 1);
  localparam logic [CNT_W-1:0] c_TRAIL_LAST = CNT_W'(HSTRAIL_TIME - 1);
  localparam logic [CNT_W-1:0] c_EXIT_LAST  = CNT_W'(HSEXIT_TIME - 1);

  lane_state_e      r_state;
  lane_state_e      w_next;
  logic [CNT_W-1:0] w_count;
  logic             w_clr;

  logic [1:0] r_lp;
  logic       r_lp_oe;
  logic       r_hs_en;
  logic       r_ready;
  logic       r_stop;
  logic [7:0] r_byte;

  logic [1:0] w_lp;
  logic       w_lp_oe;
  logic       w_hs_en;
  logic       w_ready;
  logic       w_stop;
  logic [7:0] w_byte;

  // Timer restarts from zero on every state change.
  assign w_clr = (w_next != r_state);

  dphy_state_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (LPTX_CLK),
    .rst_n   (TxRSt),
    .i_clr   (w_clr),
    .i_en    (LPTX_EN),
    .o_count (w_count)
  );

  // State register
  always_ff @(posedge LPTX_CLK or negedge TxRSt) begin
    if (!TxRSt) begin
      r_state <= ST_STOP;
    end else if (LPTX_EN) begin
      r_state <= w_next;
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STOP:     if (TxRequestHS)              w_next = ST_HS_RQST;
      ST_HS_RQST:  if (w_count == c_LPX_LAST)    w_next = ST_HS_PRPR;
      ST_HS_PRPR:  if (w_count == c_PRPR_LAST)   w_next = ST_HS_ZERO;
      ST_HS_ZERO:  if (w_count == c_ZERO_LAST)   w_next = ST_HS_SYNC;
      ST_HS_SYNC:                                w_next = ST_HS_DATA;
      ST_HS_DATA:  if (!TxRequestHS)             w_next = ST_HS_TRAIL;
      ST_HS_TRAIL: if (w_count == c_TRAIL_LAST)  w_next = ST_HS_EXIT;
      ST_HS_EXIT:  if (w_count == c_EXIT_LAST)   w_next = ST_STOP;
      default:                                   w_next = ST_STOP;
    endcase
  end

  // Moore outputs decoded from the next state so they register in step
  // with the state itself.
  always_comb begin
    w_lp    = LP11;
    w_lp_oe = 1'b1;
    w_hs_en = 1'b0;
    w_ready = 1'b0;
    w_stop  = 1'b0;
    case (w_next)
      ST_STOP:    w_stop = 1'b1;
      ST_HS_RQST: w_lp   = LP01;
      ST_HS_PRPR: w_lp   = LP00;
      ST_HS_ZERO, ST_HS_SYNC, ST_HS_TRAIL: begin
        w_lp    = LP00;
        w_lp_oe = 1'b0;
        w_hs_en = 1'b1;
      end
      ST_HS_DATA: begin
        w_lp    = LP00;
        w_lp_oe = 1'b0;
        w_hs_en = 1'b1;
        w_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // HS byte stream. Payload is captured only while already in HS_DATA, so the
  // first data cycle still shows the sync byte. The trail byte is computed once
  // on trail entry from the last byte loaded (the sync byte after an empty
  // burst) and then held.
  always_comb begin
    w_byte = r_byte;
    case (w_next)
      ST_HS_SYNC:  w_byte = SYNC_BYTE;
      ST_HS_DATA:  if (r_state == ST_HS_DATA && TxRequestHS) w_byte = TxDataHS;
      ST_HS_TRAIL: if (r_state != ST_HS_TRAIL) w_byte = {8{~r_byte[7]}};
      default:     w_byte = 8'h00;
    endcase
  end

  // Output registers
  always_ff @(posedge LPTX_CLK or negedge TxRSt) begin
    if (!TxRSt) begin
      r_lp    <= LP11;
      r_lp_oe <= 1'b0;
      r_hs_en <= 1'b0;
      r_ready <= 1'b0;
      r_stop  <= 1'b1;
      r_byte  <= 8'h00;
    end else if (LPTX_EN) begin
      r_lp    <= w_lp;
      r_lp_oe <= w_lp_oe;
      r_hs_en <= w_hs_en;
      r_ready <= w_ready;
      r_stop  <= w_stop;
      r_byte  <= w_byte;
    end
  end

  assign LP_Dp       = r_lp[1];
  assign LP_Dn       = r_lp[0];
  assign LP_OE       = r_lp_oe;
  assign HSTX_EN     = r_hs_en;
  assign HSCLK_EN    = r_hs_en;
  assign TxReadyHS   = r_ready;
  assign TxStopState = r_stop;
  assign HS_Byte     = r_byte;
  assign Lane_State  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_dphy_hs_tx_seq.sv
// ============================================================================
// Module   : tb_dphy_hs_tx_seq
// Purpose  : Self-checking bench for dphy_hs_tx_seq. Expected lane behaviour
//            is laid out as a per-cycle timeline built from phase durations
//            and the per-phase output table; two instances cover the default
//            and the 1-cycle LP timing configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dphy_hs_tx_seq;

  typedef struct packed {
    logic [17:0] v;
    logic [17:0] m;
  } exp_t;

  // Observed vector: {oe,dp,dn,hstx,hsclk,ready,stop,state[2:0],byte[7:0]}
  localparam logic [17:0] RESET_V = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00};

  // Per-instance timing: index 0 = defaults, index 1 = short configuration.
  int P_LPX[2] = '{10, 1};
  int P_PRP[2] = '{15, 1};
  int P_ZR[2]  = '{20, 2};
  int P_TR[2]  = '{8, 2};
  int P_EX[2]  = '{20, 3};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       req;
  logic [7:0] data;

  logic       rdy0, stp0, oe0, dp0, dn0, hs0, hc0;
  logic [7:0] b0;
  logic [2:0] st0;
  logic       rdy1, stp1, oe1, dp1, dn1, hs1, hc1;
  logic [7:0] b1;
  logic [2:0] st1;

  int total = 0;
  int bad   = 0;

  exp_t       exp_q[$];
  logic [7:0] pay[$];

  dphy_hs_tx_seq u_dut0 (
    .LPTX_CLK    (clk),
    .TxRSt       (rst_n),
    .LPTX_EN     (en),
    .TxRequestHS (req),
    .TxDataHS    (data),
    .TxReadyHS   (rdy0),
    .TxStopState (stp0),
    .LP_OE       (oe0),
    .LP_Dp       (dp0),
    .LP_Dn       (dn0),
    .HSTX_EN     (hs0),
    .HSCLK_EN    (hc0),
    .HS_Byte     (b0),
    .Lane_State  (st0)
  );

  dphy_hs_tx_seq #(
    .CNT_W          (6),
    .LPX_TIME       (1),
    .HSPREPARE_TIME (1),
    .HSZERO_TIME    (2),
    .HSTRAIL_TIME   (2),
    .HSEXIT_TIME    (3)
  ) u_dut1 (
    .LPTX_CLK    (clk),
    .TxRSt       (rst_n),
    .LPTX_EN     (en),
    .TxRequestHS (req),
    .TxDataHS    (data),
    .TxReadyHS   (rdy1),
    .TxStopState (stp1),
    .LP_OE       (oe1),
    .LP_Dp       (dp1),
    .LP_Dn       (dn1),
    .HSTX_EN     (hs1),
    .HSCLK_EN    (hc1),
    .HS_Byte     (b1),
    .Lane_State  (st1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [17:0] obs(input int sel);
    if (sel == 0) return {oe0, dp0, dn0, hs0, hc0, rdy0, stp0, st0, b0};
    return {oe1, dp1, dn1, hs1, hc1, rdy1, stp1, st1, b1};
  endfunction

  // Spec output table per phase; LP levels are don't-care while LP is off,
  // and the HS byte is only defined from HS-Request through HS-Trail.
  function automatic exp_t mk(input int ph, input logic [7:0] b);
    exp_t e;
    logic oe, dp, dn, hs, rdy, stp;
    oe = 1'b1; dp = 1'b1; dn = 1'b1; hs = 1'b0; rdy = 1'b0; stp = 1'b0;
    case (ph)
      0: stp = 1'b1;
      1: dp = 1'b0;
      2: begin dp = 1'b0; dn = 1'b0; end
      3, 4, 6: begin oe = 1'b0; hs = 1'b1; end
      5: begin oe = 1'b0; hs = 1'b1; rdy = 1'b1; end
      default: ;
    endcase
    e.v = {oe, dp, dn, hs, hs, rdy, stp, 3'(ph), b};
    e.m = '1;
    if (!oe) e.m[16:15] = 2'b00;
    if (ph == 0 || ph == 7) e.m[7:0] = 8'h00;
    return e;
  endfunction

  // Timeline starting at the first HS-Request cycle, for a burst of n bytes
  // taken from pay[].
  task automatic build(input int sel, input int n, input int n_stop);
    logic [7:0] last;
    exp_q.delete();
    repeat (P_LPX[sel]) exp_q.push_back(mk(1, 8'h00));
    repeat (P_PRP[sel]) exp_q.push_back(mk(2, 8'h00));
    repeat (P_ZR[sel])  exp_q.push_back(mk(3, 8'h00));
    exp_q.push_back(mk(4, 8'hB8));
    exp_q.push_back(mk(5, 8'hB8));
    for (int i = 0; i < n; i++) exp_q.push_back(mk(5, pay[i]));
    last = (n > 0) ? pay[n-1] : 8'hB8;
    repeat (P_TR[sel]) exp_q.push_back(mk(6, {8{~last[7]}}));
    repeat (P_EX[sel]) exp_q.push_back(mk(7, 8'h00));
    repeat (n_stop)    exp_q.push_back(mk(0, 8'h00));
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // Drives one burst and checks every wall cycle against the timeline.
  // frz_at/frz_len: hold LPTX_EN low for frz_len edges at timeline index frz_at.
  // rereq_at: raise the request from that index on (next burst back to back).
  task automatic run_burst(input string name, input int sel, input int n,
                           input bit drop_early, input int frz_at, input int frz_len,
                           input int rereq_at, input bit skip_start);
    int t, d0, frz_left;
    logic [17:0] o;
    exp_t e;
    d0 = P_LPX[sel] + P_PRP[sel] + P_ZR[sel] + 1;
    build(sel, n, (rereq_at >= 0) ? 1 : 2);
    frz_left = frz_len;
    if (!skip_start) begin
      req = 1'b1; en = 1'b1; data = 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    t = 0;
    while (t < exp_q.size()) begin
      o = obs(sel);
      e = exp_q[t];
      total++;
      if ((o & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s t=%0d got=%h exp=%h mask=%h", name, t, o, e.v, e.m);
      end
      req = drop_early ? 1'b0 : (t < d0 + n);
      if (rereq_at >= 0 && t >= rereq_at) req = 1'b1;
      data = (t >= d0 && t < d0 + n) ? pay[t-d0] : 8'($urandom);
      if (t == frz_at && frz_left > 0) begin
        en = 1'b0;
        frz_left--;
      end else begin
        en = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      if (en) t++;
    end
    en = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; req = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (obs(0) !== RESET_V) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", obs(0), RESET_V);
    end
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (obs(0) !== RESET_V) begin
      bad++; $display("FAIL reset_disabled_edge got=%h exp=%h", obs(0), RESET_V);
    end
    en = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ((obs(0) & mk(0, 0).m) !== (mk(0, 0).v & mk(0, 0).m)) begin
      bad++; $display("FAIL reset_first_edge got=%h exp=%h", obs(0), mk(0, 0).v);
    end
  endtask

  task automatic test_single_burst();
    pay.delete();
    pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h93);
    run_burst("burst_3", 0, 3, 1'b0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_random_bursts();
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(0, 5);
      fill_pay(n);
      run_burst("burst_rand", 0, n, 1'b0, -1, 0, -1, 1'b0);
    end
  endtask

  task automatic test_pulse();
    pay.delete();
    run_burst("pulse", 0, 0, 1'b1, -1, 0, -1, 1'b0);
  endtask

  task automatic test_enable_freeze();
    int n;
    pay.delete();
    pay.push_back(8'h5A);
    // Five disabled edges in the middle of LP-00.
    run_burst("freeze_prpr", 0, 1, 1'b0, P_LPX[0] + 3, 5, -1, 1'b0);
    n = $urandom_range(2, 4);
    fill_pay(n);
    run_burst("freeze_data", 0, n, 1'b0, P_LPX[0] + P_PRP[0] + P_ZR[0] + 2,
              $urandom_range(1, 4), -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, d0;
    d0 = P_LPX[0] + P_PRP[0] + P_ZR[0] + 1;
    n = $urandom_range(1, 3);
    fill_pay(n);
    // Request comes back at the start of trail and must wait for Stop.
    run_burst("b2b_first", 0, n, 1'b0, -1, 0, d0 + n + 1, 1'b0);
    n = $urandom_range(0, 3);
    fill_pay(n);
    run_burst("b2b_second", 0, n, 1'b0, -1, 0, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [17:0] o;
    d0 = P_LPX[0] + P_PRP[0] + P_ZR[0] + 1;
    do_reset();
    req = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < d0 + 2; i++) begin
      data = 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    o = obs(0);
    total++;
    if (o[12:8] !== 5'b1_0_101) begin
      bad++; $display("FAIL mid_in_data got=%b exp=%b", o[12:8], 5'b1_0_101);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs(0) !== RESET_V) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", obs(0), RESET_V);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (obs(0) !== RESET_V) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", obs(0), RESET_V);
    end
    req = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (obs(0) !== RESET_V) begin
      bad++; $display("FAIL release_no_edge got=%h exp=%h", obs(0), RESET_V);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ((obs(0) & mk(0, 0).m) !== (mk(0, 0).v & mk(0, 0).m)) begin
      bad++; $display("FAIL release_stop got=%h exp=%h", obs(0), mk(0, 0).v);
    end
    fill_pay(2);
    run_burst("after_reset", 0, 2, 1'b0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_short_lp();
    int n;
    do_reset();
    n = $urandom_range(1, 3);
    fill_pay(n);
    run_burst("short_lp", 1, n, 1'b0, -1, 0, -1, 1'b0);
    pay.delete();
    run_burst("short_lp_pulse", 1, 0, 1'b1, -1, 0, -1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 1'b0; data = 8'h00;
    test_reset();
    test_single_burst();
    test_random_bursts();
    test_pulse();
    test_enable_freeze();
    test_back_to_back();
    test_reset_mid();
    test_short_lp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
